// File: rtl/kv_update_writer.sv
// kv_update_writer: write-side buffer for the combinational key/value store.
// It accepts update requests over a valid/ready handshake and queues them in a
// small FIFO. A repeat write to a key that is already queued overwrites that
// entry's value in place. Entries drain at most one per cycle onto a
// registered update strobe.
//
// Ports:
//   clk, reset                         clock, asynchronous active-high reset
//   in_valid/in_ready/in_key/in_value  request handshake
//   hold                               suppress draining this cycle
//   flush                              synchronous discard of queue and output strobe
//   update_valid/update_key/update_value  registered write port to the store
//   pending                            number of queued entries (excludes output reg)
//   empty                              nothing queued and no strobe in flight
module kv_update_writer #(
    parameter int unsigned KEY_WIDTH = 32,
    parameter int unsigned VAL_WIDTH = 32,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [KEY_WIDTH-1:0]         in_key,
    input  logic [VAL_WIDTH-1:0]         in_value,
    input  logic                         hold,
    input  logic                         flush,
    output logic                         update_valid,
    output logic [KEY_WIDTH-1:0]         update_key,
    output logic [VAL_WIDTH-1:0]         update_value,
    output logic [$clog2(DEPTH+1)-1:0]   pending,
    output logic                         empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    if (KEY_WIDTH == 0) begin : g_bad_key_width
        $fatal(1, "kv_update_writer: KEY_WIDTH must be > 0");
    end
    if (VAL_WIDTH == 0) begin : g_bad_val_width
        $fatal(1, "kv_update_writer: VAL_WIDTH must be > 0");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $fatal(1, "kv_update_writer: DEPTH must be a power of two >= 2");
    end

    logic [KEY_WIDTH-1:0] key_mem [DEPTH];
    logic [VAL_WIDTH-1:0] val_mem [DEPTH];
    logic [DEPTH-1:0]     entry_valid;
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [CNT_W-1:0]     count;

    logic             pop;
    logic             accept;
    logic             match_hit;
    logic [PTR_W-1:0] match_idx;
    logic             push;
    logic             coalesce;

    assign in_ready = (count < CNT_W'(DEPTH));
    assign pending  = count;
    assign empty    = (count == '0) && !update_valid;

    always_comb begin
        pop       = (count != '0) && !hold;
        accept    = in_valid && in_ready;
        match_hit = 1'b0;
        match_idx = '0;
        // The head leaving on this edge is not a coalesce target; a matching
        // request becomes a fresh entry so the popped value goes out unchanged.
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (entry_valid[i] && (key_mem[i] == in_key)
                && !(pop && (PTR_W'(i) == head))) begin
                match_hit = 1'b1;
                match_idx = PTR_W'(i);
            end
        end
        push     = accept && !match_hit && !flush;
        coalesce = accept && match_hit && !flush;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            entry_valid  <= '0;
            update_valid <= 1'b0;
            update_key   <= '0;
            update_value <= '0;
        end else if (flush) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            entry_valid  <= '0;
            update_valid <= 1'b0;
        end else begin
            update_valid <= pop;
            if (pop) begin
                update_key        <= key_mem[head];
                update_value      <= val_mem[head];
                entry_valid[head] <= 1'b0;
                head              <= head + PTR_W'(1);
            end
            if (push) begin
                entry_valid[tail] <= 1'b1;
                tail              <= tail + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Entry payload storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push) begin
            key_mem[tail] <= in_key;
            val_mem[tail] <= in_value;
        end
        if (coalesce) begin
            val_mem[match_idx] <= in_value;
        end
    end

endmodule

// File: tb/tb_kv_update_writer.sv
module tb_kv_update_writer;

    localparam int unsigned KW    = 32;
    localparam int unsigned VW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [KW-1:0] in_key;
    logic [VW-1:0] in_value;
    logic          hold;
    logic          flush;
    logic          update_valid;
    logic [KW-1:0] update_key;
    logic [VW-1:0] update_value;
    logic [CW-1:0] pending;
    logic          empty;

    kv_update_writer #(
        .KEY_WIDTH (KW),
        .VAL_WIDTH (VW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_key       (in_key),
        .in_value     (in_value),
        .hold         (hold),
        .flush        (flush),
        .update_valid (update_valid),
        .update_key   (update_key),
        .update_value (update_value),
        .pending      (pending),
        .empty        (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: queue of pending updates plus the output register.
    typedef struct {
        logic [KW-1:0] k;
        logic [VW-1:0] v;
    } ent_t;

    ent_t          q[$];
    logic          m_valid;
    logic [KW-1:0] m_key;
    logic [VW-1:0] m_val;

    task automatic model_reset();
        q.delete();
        m_valid = 1'b0;
        m_key   = '0;
        m_val   = '0;
    endtask

    task automatic model_next(input logic v, input logic [KW-1:0] k, input logic [VW-1:0] d,
                              input logic h, input logic f);
        bit do_pop;
        bit acc;
        bit hit;
        if (f) begin
            q.delete();
            m_valid = 1'b0;
        end else begin
            do_pop = (q.size() > 0) && !h;
            acc    = v && (q.size() < int'(DEPTH));
            if (do_pop) begin
                m_valid = 1'b1;
                m_key   = q[0].k;
                m_val   = q[0].v;
                void'(q.pop_front());
            end else begin
                m_valid = 1'b0;
            end
            if (acc) begin
                hit = 0;
                foreach (q[i]) begin
                    if (q[i].k == k) begin
                        q[i].v = d;
                        hit    = 1;
                    end
                end
                if (!hit) q.push_back('{k: k, v: d});
            end
        end
    endtask

    task automatic compare_model();
        check_eq("update_valid", 64'(update_valid), 64'(m_valid));
        check_eq("update_key", 64'(update_key), 64'(m_key));
        check_eq("update_value", 64'(update_value), 64'(m_val));
        check_eq("pending", 64'(pending), 64'(q.size()));
        check_eq("in_ready", 64'(in_ready), 64'(q.size() < int'(DEPTH)));
        check_eq("empty", 64'(empty), 64'((q.size() == 0) && !m_valid));
    endtask

    // Called at a negedge: check, drive, advance model across the next posedge.
    task automatic step(input logic v, input logic [KW-1:0] k, input logic [VW-1:0] d,
                        input logic h, input logic f);
        compare_model();
        in_valid = v;
        in_key   = k;
        in_value = d;
        hold     = h;
        flush    = f;
        model_next(v, k, d, h, f);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic h);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, h, 1'b0);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_key   = '0;
        in_value = '0;
        hold     = 1'b0;
        flush    = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("reset_valid", 64'(update_valid), 64'd0);
        check_eq("reset_pending", 64'(pending), 64'd0);
        check_eq("reset_ready", 64'(in_ready), 64'd1);
        check_eq("reset_empty", 64'(empty), 64'd1);
        reset = 1'b0;
        @(negedge clk);

        // 1: single request latency
        step(1'b1, 32'h100, 32'hA, 1'b0, 1'b0);
        check_eq("t1_no_bypass", 64'(update_valid), 64'd0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        check_eq("t1_strobe", 64'(update_valid), 64'd1);
        check_eq("t1_key", 64'(update_key), 64'h100);
        check_eq("t1_val", 64'(update_value), 64'hA);
        idle(1, 1'b0);
        check_eq("t1_done", 64'(update_valid), 64'd0);
        check_eq("t1_empty", 64'(empty), 64'd1);

        // 2: fill under hold, fifth request refused, drain in order
        for (int i = 1; i <= 4; i++) step(1'b1, KW'(i * 16), VW'(i), 1'b1, 1'b0);
        check_eq("t2_pending", 64'(pending), 64'd4);
        check_eq("t2_full", 64'(in_ready), 64'd0);
        step(1'b1, 32'h50, 32'h5, 1'b1, 1'b0);
        check_eq("t2_held", 64'(pending), 64'd4);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        check_eq("t2_first", 64'(update_key), 64'h10);
        check_eq("t2_ready", 64'(in_ready), 64'd1);
        idle(5, 1'b0);

        // 3: coalesce keeps position, newest value
        step(1'b1, 32'h10, 32'h1, 1'b1, 1'b0);
        step(1'b1, 32'h20, 32'h2, 1'b1, 1'b0);
        step(1'b1, 32'h10, 32'h9, 1'b1, 1'b0);
        check_eq("t3_pending", 64'(pending), 64'd2);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        check_eq("t3_val", 64'(update_value), 64'h9);
        idle(3, 1'b0);

        // 4: same-key request racing the head pop becomes a new entry
        step(1'b1, 32'h50, 32'h3, 1'b1, 1'b0);
        step(1'b1, 32'h50, 32'h7, 1'b0, 1'b0);
        check_eq("t4_old_val", 64'(update_value), 64'h3);
        check_eq("t4_pending", 64'(pending), 64'd1);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        check_eq("t4_new_val", 64'(update_value), 64'h7);
        idle(2, 1'b0);

        // 5: flush drops queue and concurrent request
        for (int i = 1; i <= 3; i++) step(1'b1, KW'(32'h70 + i), VW'(i), 1'b1, 1'b0);
        step(1'b1, 32'h60, 32'h6, 1'b0, 1'b1);
        check_eq("t5_pending", 64'(pending), 64'd0);
        check_eq("t5_valid", 64'(update_valid), 64'd0);
        check_eq("t5_ready", 64'(in_ready), 64'd1);
        idle(4, 1'b0);

        // 6: asynchronous reset mid-drain
        for (int i = 1; i <= 3; i++) step(1'b1, KW'(32'h80 + i), VW'(i), 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        check_eq("t6_draining", 64'(update_valid), 64'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_eq("t6_valid_drop", 64'(update_valid), 64'd0);
        check_eq("t6_pending_drop", 64'(pending), 64'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        check_eq("t6_ready", 64'(in_ready), 64'd1);
        check_eq("t6_empty", 64'(empty), 64'd1);

        // Random traffic with a small key space to exercise coalescing
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 99) < 70),
                 KW'($urandom_range(0, 5)),
                 VW'($urandom),
                 1'($urandom_range(0, 99) < 30),
                 1'($urandom_range(0, 99) < 3));
        end
        idle(DEPTH + 2, 1'b0);
        compare_model();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
